bfly_sdf_stage: RTL

- Parametrised radix-2 single-delay-feedback butterfly stage for the FFT datapath; successor to the fixed 16-lane/9-bit butterfly.
- Pairs beat k of a group with beat k+DIST_BEATS, across NUM parallel complex lanes.
- Emits DIST_BEATS sum beats, then DIST_BEATS difference beats.
- Adds selectable per-group divide-by-2 scaling, tolerates gapped valid_in, and overlaps the difference drain with the next group's fill for gap-free streaming.

---
 rtl/bfly_pkg.sv | 32 +++
 rtl/bfly_sdf_stage_delay_buf.sv | 24 ++
 rtl/bfly_sdf_stage.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/bfly_pkg.sv
// Shared types and helpers for the radix-2 SDF butterfly stage.
// Lane packing: lane j of a NUM-lane bus sits at [j*W +: W]; buffer slots keep all re lanes below all im lanes.
package bfly_pkg;

  localparam int BFLY_IN_WIDTH   = 9;
  localparam int BFLY_NUM        = 16;
  localparam int BFLY_DIST_BEATS = 16;
  localparam int BFLY_ACC_W      = 32;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    PAIR  = 2'd1,
    DRAIN = 2'd2
  } bfly_state_e;

  // Round-half-up halving: (x + 1) >>> 1 when en, pass-through otherwise.
  function automatic logic [BFLY_ACC_W-1:0] halve_rnd(input logic [BFLY_ACC_W-1:0] x,
                                                       input logic en);
    logic signed [BFLY_ACC_W-1:0] sx;
    sx = signed'(x);
    return en ? BFLY_ACC_W'((sx + 1) >>> 1) : x;
  endfunction

  function automatic int lane_base(input int lane, input int width);
    return lane * width;
  endfunction

  function automatic int im_base(input int lane, input int width, input int num);
    return (num + lane) * width;
  endfunction

endpackage

// File: rtl/bfly_sdf_stage_delay_buf.sv
// DEPTH-slot register array, one write port and one combinational read port; 0-cycle read latency.
// A read and write to the same slot in one cycle returns the old contents; no backpressure, no reset.
module bfly_delay_buf #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 320,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_dat
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/bfly_sdf_stage.sv
// Radix-2 single-delay-feedback butterfly: pairs beat k with beat k+DIST_BEATS over NUM complex lanes.
// Outputs are registered (1 cycle after the pairing beat); input is never stalled, drain overlaps next fill.
module bfly_sdf_stage
  import bfly_pkg::*;
#(
  parameter int IN_WIDTH   = BFLY_IN_WIDTH,
  parameter int OUT_WIDTH  = IN_WIDTH + 1,
  parameter int NUM        = BFLY_NUM,
  parameter int DIST_BEATS = BFLY_DIST_BEATS
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      scale_en,
  input  logic                      valid_in,
  input  logic [IN_WIDTH*NUM-1:0]   din_i,
  input  logic [IN_WIDTH*NUM-1:0]   din_q,
  output logic                      valid_out,
  output logic [OUT_WIDTH*NUM-1:0]  do_re,
  output logic [OUT_WIDTH*NUM-1:0]  do_im,
  output logic                      out_sum,
  output logic                      out_last
);

  localparam int AW  = $clog2(DIST_BEATS);
  localparam int CW  = $clog2(DIST_BEATS + 1);
  localparam int HW  = NUM * OUT_WIDTH;
  localparam int SW  = 2 * HW;
  localparam int EXT = BFLY_ACC_W - OUT_WIDTH;

  localparam logic [AW-1:0] LAST_IDX  = AW'(DIST_BEATS - 1);
  localparam logic [CW-1:0] FILL_LAST = CW'(DIST_BEATS - 1);
  localparam logic [CW-1:0] FILL_FULL = CW'(DIST_BEATS);

  bfly_state_e state, state_nxt;
  logic [CW-1:0] fill_cnt, fill_nxt;
  logic [AW-1:0] pair_cnt, pair_nxt;
  logic [AW-1:0] drain_cnt, drain_nxt;
  logic          scale_lat, scale_nxt;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [SW-1:0] wr_dat;
  logic [AW-1:0] rd_addr;
  logic [SW-1:0] rd_dat;

  logic [SW-1:0] fill_dat;
  logic [SW-1:0] sum_dat;
  logic [SW-1:0] diff_dat;

  logic          vld_nxt, sum_flag_nxt, last_nxt;
  logic [HW-1:0] re_nxt, im_nxt;

  bfly_delay_buf #(
    .DEPTH (DIST_BEATS),
    .WIDTH (SW),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_dat  (wr_dat),
    .rd_addr (rd_addr),
    .rd_dat  (rd_dat)
  );

  // Per-lane sign extension and add/sub; arithmetic is carried at accumulator width then truncated.
  for (genvar j = 0; j < NUM; j++) begin : g_lane
    localparam int IB = lane_base(j, IN_WIDTH);
    localparam int RB = lane_base(j, OUT_WIDTH);
    localparam int QB = im_base(j, OUT_WIDTH, NUM);

    logic [OUT_WIDTH-1:0] b_re, b_im, a_re, a_im;

    assign b_re = {{(OUT_WIDTH-IN_WIDTH){din_i[IB+IN_WIDTH-1]}}, din_i[IB +: IN_WIDTH]};
    assign b_im = {{(OUT_WIDTH-IN_WIDTH){din_q[IB+IN_WIDTH-1]}}, din_q[IB +: IN_WIDTH]};
    assign a_re = rd_dat[RB +: OUT_WIDTH];
    assign a_im = rd_dat[QB +: OUT_WIDTH];

    assign fill_dat[RB +: OUT_WIDTH] = b_re;
    assign fill_dat[QB +: OUT_WIDTH] = b_im;

    assign sum_dat[RB +: OUT_WIDTH] = OUT_WIDTH'(halve_rnd(
        {{EXT{a_re[OUT_WIDTH-1]}}, a_re} + {{EXT{b_re[OUT_WIDTH-1]}}, b_re}, scale_lat));
    assign sum_dat[QB +: OUT_WIDTH] = OUT_WIDTH'(halve_rnd(
        {{EXT{a_im[OUT_WIDTH-1]}}, a_im} + {{EXT{b_im[OUT_WIDTH-1]}}, b_im}, scale_lat));
    assign diff_dat[RB +: OUT_WIDTH] = OUT_WIDTH'(halve_rnd(
        {{EXT{a_re[OUT_WIDTH-1]}}, a_re} - {{EXT{b_re[OUT_WIDTH-1]}}, b_re}, scale_lat));
    assign diff_dat[QB +: OUT_WIDTH] = OUT_WIDTH'(halve_rnd(
        {{EXT{a_im[OUT_WIDTH-1]}}, a_im} - {{EXT{b_im[OUT_WIDTH-1]}}, b_im}, scale_lat));
  end

  always_comb begin
    state_nxt    = state;
    fill_nxt     = fill_cnt;
    pair_nxt     = pair_cnt;
    drain_nxt    = drain_cnt;
    scale_nxt    = scale_lat;
    wr_en        = 1'b0;
    wr_addr      = fill_cnt[AW-1:0];
    wr_dat       = fill_dat;
    rd_addr      = pair_cnt;
    vld_nxt      = 1'b0;
    sum_flag_nxt = 1'b0;
    last_nxt     = 1'b0;
    re_nxt       = do_re;
    im_nxt       = do_im;

    case (state)
      FILL: begin
        if (valid_in) begin
          wr_en = 1'b1;
          if (fill_cnt == '0) scale_nxt = scale_en;
          if (fill_cnt == FILL_LAST) begin
            fill_nxt  = '0;
            state_nxt = PAIR;
          end else begin
            fill_nxt = fill_cnt + 1'b1;
          end
        end
      end

      PAIR: begin
        if (valid_in) begin
          wr_en        = 1'b1;
          wr_addr      = pair_cnt;
          wr_dat       = diff_dat;
          vld_nxt      = 1'b1;
          sum_flag_nxt = 1'b1;
          re_nxt       = sum_dat[HW-1:0];
          im_nxt       = sum_dat[SW-1:HW];
          if (pair_cnt == LAST_IDX) begin
            pair_nxt  = '0;
            drain_nxt = '0;
            state_nxt = DRAIN;
          end else begin
            pair_nxt = pair_cnt + 1'b1;
          end
        end
      end

      DRAIN: begin
        // Fill of the next group never passes the drain pointer, so same-slot
        // writes only ever replace a diff that is being read this very cycle.
        rd_addr  = drain_cnt;
        vld_nxt  = 1'b1;
        last_nxt = (drain_cnt == LAST_IDX);
        re_nxt   = rd_dat[HW-1:0];
        im_nxt   = rd_dat[SW-1:HW];
        if (valid_in) begin
          wr_en = 1'b1;
          if (fill_cnt == '0) scale_nxt = scale_en;
          fill_nxt = fill_cnt + 1'b1;
        end
        if (drain_cnt == LAST_IDX) begin
          drain_nxt = '0;
          if (fill_nxt == FILL_FULL) begin
            fill_nxt  = '0;
            state_nxt = PAIR;
          end else begin
            state_nxt = FILL;
          end
        end else begin
          drain_nxt = drain_cnt + 1'b1;
        end
      end

      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= FILL;
      fill_cnt  <= '0;
      pair_cnt  <= '0;
      drain_cnt <= '0;
      scale_lat <= 1'b0;
      valid_out <= 1'b0;
      out_sum   <= 1'b0;
      out_last  <= 1'b0;
      do_re     <= '0;
      do_im     <= '0;
    end else begin
      state     <= state_nxt;
      fill_cnt  <= fill_nxt;
      pair_cnt  <= pair_nxt;
      drain_cnt <= drain_nxt;
      scale_lat <= scale_nxt;
      valid_out <= vld_nxt;
      out_sum   <= sum_flag_nxt;
      out_last  <= last_nxt;
      do_re     <= re_nxt;
      do_im     <= im_nxt;
    end
  end

endmodule
